// File: rtl/etc_tile_driver_if.sv
// Bundle of job control, operand stream, core and result handshake signals for
// the 4x4 tile issue driver.
interface etc_tile_driver_if #(
    parameter int W  = 16,
    parameter int KW = 8
);
    logic                       start;
    logic [1:0]                 op_in;
    logic [KW-1:0]              k_tiles;
    logic                       busy;

    logic                       tile_valid;
    logic                       tile_ready;
    logic [3:0][3:0][W-1:0]     a_tile;
    logic [3:0][3:0][W-1:0]     b_tile;

    logic [1:0]                 core_op;
    logic [3:0][3:0][W-1:0]     core_a;
    logic [3:0][3:0][W-1:0]     core_b;
    logic [3:0][3:0][W-1:0]     core_out;

    logic                       res_valid;
    logic                       res_ready;
    logic [3:0][3:0][W-1:0]     res;

    // Environment side: job source, operand fetch, tile core and result sink.
    modport master (
        output start, op_in, k_tiles, tile_valid, a_tile, b_tile, core_out, res_ready,
        input  busy, tile_ready, core_op, core_a, core_b, res_valid, res
    );

    modport slave (
        input  start, op_in, k_tiles, tile_valid, a_tile, b_tile, core_out, res_ready,
        output busy, tile_ready, core_op, core_a, core_b, res_valid, res
    );
endinterface

// File: rtl/etc_tile_driver.sv
// Issue-side controller for the 4x4 tile core: feeds K operand pairs, tracks the
// core latency with a valid pipe and reduces the K partial tiles into one result.
module etc_tile_driver #(
    parameter int W        = 16,
    parameter int CORE_LAT = 2,
    parameter int KW       = 8
) (
    input logic              clk,
    input logic              rst,
    etc_tile_driver_if.slave bus
);

    typedef logic [3:0][3:0][W-1:0] tile_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          stateNext;

    logic [1:0]      opQ;
    logic [KW-1:0]   kQ;
    logic [KW-1:0]   issueCnt;
    logic [KW-1:0]   retireCnt;
    logic [CORE_LAT:0] vldPipe;

    tile_t           coreA;
    tile_t           coreB;
    tile_t           acc;

    logic            startOk;
    logic            accept;
    logic            retire;
    logic            lastIssue;
    logic            lastRetire;
    logic            tileReady;
    logic            resValid;
    logic            busyInt;

    // Element reduce: wrapping sum for MMA, unsigned min/max for the tropical ops.
    function automatic logic [W-1:0] reduceElem(input logic [1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W-1:0] r;
        unique case (op)
            2'd0:    r = a + b;
            2'd1:    r = (b < a) ? b : a;
            default: r = (b > a) ? b : a;
        endcase
        return r;
    endfunction

    function automatic tile_t reduceTile(input logic [1:0] op,
                                         input tile_t a,
                                         input tile_t b);
        tile_t r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[i][j] = reduceElem(op, a[i][j], b[i][j]);
            end
        end
        return r;
    endfunction

    assign startOk    = bus.start && (bus.k_tiles != '0);
    assign accept     = bus.tile_valid && (state == ISSUE);
    assign retire     = vldPipe[CORE_LAT];
    assign lastIssue  = ((issueCnt + KW'(1)) == kQ);
    assign lastRetire = ((retireCnt + KW'(1)) == kQ);

    always_comb begin
        stateNext = state;
        tileReady = 1'b0;
        resValid  = 1'b0;
        busyInt   = 1'b1;
        unique case (state)
            IDLE: begin
                busyInt = 1'b0;
                if (startOk) stateNext = ISSUE;
            end
            ISSUE: begin
                tileReady = 1'b1;
                if (accept && lastIssue) stateNext = DRAIN;
            end
            DRAIN: begin
                if (retire && lastRetire) stateNext = DONE;
            end
            DONE: begin
                resValid = 1'b1;
                if (bus.res_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Stage p0: operand registers feeding the core, plus the latency-matched valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            opQ       <= '0;
            kQ        <= '0;
            issueCnt  <= '0;
            retireCnt <= '0;
            vldPipe   <= '0;
            coreA     <= '0;
            coreB     <= '0;
            acc       <= '0;
        end else begin
            state   <= stateNext;
            vldPipe <= {vldPipe[CORE_LAT-1:0], accept};

            if ((state == IDLE) && startOk) begin
                opQ       <= bus.op_in;
                kQ        <= bus.k_tiles;
                issueCnt  <= '0;
                retireCnt <= '0;
            end

            if (accept) begin
                coreA    <= bus.a_tile;
                coreB    <= bus.b_tile;
                issueCnt <= issueCnt + KW'(1);
            end

            // Stage p1: retire; the first partial seeds acc so no identity value is needed.
            if (retire) begin
                acc       <= (retireCnt == '0) ? bus.core_out
                                               : reduceTile(opQ, acc, bus.core_out);
                retireCnt <= retireCnt + KW'(1);
            end
        end
    end

    assign bus.busy       = busyInt;
    assign bus.tile_ready = tileReady;
    assign bus.res_valid  = resValid;
    assign bus.res        = acc;
    assign bus.core_op    = opQ;
    assign bus.core_a     = coreA;
    assign bus.core_b     = coreB;

endmodule

// File: doc/etc_tile_driver.md
# etc_tile_driver

Issue-side controller for the extended-tensor-core 4x4 tile unit. It accepts a stream of A/B operand tile pairs and drives them into the tile core one pair per cycle. It tracks the core's fixed pipeline latency and reduces the K partial result tiles element-wise with the semiring's reduce operator: sum for MMA, min or max otherwise. It presents one 4x4 result tile per job over a valid/ready handshake, and sits between the operand fetch logic and the tile core.

## Interface
- W, 16, element width in bits (matches core W)
- CORE_LAT, 2, core register stages from operand input to result output
- KW, 8, width of the tile-count field
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request; sampled only in IDLE
- op_in  in  2  job operation, captured at start: 0 = sum, 1 = min, 2/3 = max
- k_tiles  in  KW  number of A/B tile pairs in the job, captured at start
- busy  out  1  high from accepted start until result handshake completes
- tile_valid  in  1  operand pair available
- tile_ready  out  1  driver accepts a pair this cycle
- a_tile, b_tile  in  [3:0][3:0][W-1:0]  operand tiles
- core_op  out  2  operation select to the core
- core_a, core_b  out  [3:0][3:0][W-1:0]  operands to the core
- core_out  in  [3:0][3:0][W-1:0]  core result
- res_valid  out  1  result tile valid
- res_ready  in  1  consumer accepts result
- res  out  [3:0][3:0][W-1:0]  reduced result tile

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE when start=1 and k_tiles≠0. On that transition, latch op_in into core_op and k_tiles, clear issue and retire counters, and set busy. A start with k_tiles=0 is ignored. start outside IDLE is ignored.
- ISSUE: tile_ready=1. On tile_valid&&tile_ready, register a_tile/b_tile into core_a/core_b, increment the issue count, and push 1 into a valid shift pipe of depth CORE_LAT+1. Otherwise push 0; core_a/core_b hold.
- The last accept (issue count reaches k) moves the FSM to DRAIN in the same edge. tile_ready=0 in DRAIN, DONE, and IDLE.
- Retire: when the pipe output is 1, core_out is the partial for that pair.
  - First retire loads acc directly, with no identity value.
  - Later retires: op 0 does acc = acc + core_out mod 2^W. Op 1 does unsigned min per element. Op 2/3 does unsigned max per element.
  - Each retire increments the retire count.
- DRAIN → DONE on the edge that performs retire number k. In DONE: res_valid=1 and res=acc, both stable until res_ready=1. DONE → IDLE on res_valid&&res_ready, which also clears busy.
- core_op is constant for the whole job, so the core's op sampling point is irrelevant.
- Reset: state IDLE; busy, tile_ready, res_valid, core_op, core_a, core_b, res/acc, counters, and pipe all 0.
- Reset mid-job aborts the job with no result. Partials still in flight are discarded because the pipe is cleared.

## Timing
- An accept at edge E puts operands on core_a/core_b after E. core_out for that pair is valid in the cycle after E+CORE_LAT, and is accumulated at edge E+CORE_LAT+1.
- Back-to-back accepts issue one pair per cycle.
- k gapless pairs with the first accept at edge E0: last accept at E0+k−1. res_valid asserts in the cycle after edge E0+k+CORE_LAT (3 for CORE_LAT=2).
- tile_valid bubbles delay completion one cycle per bubble. Accumulation order equals issue order.
- Minimum IDLE→IDLE for k=1 with res_ready held high:
  - Edge 0: start accepted.
  - Edge 1: pair accepted.
  - Edge 4: retire; res_valid asserts after this edge.
  - Edge 5: handshake.
- A new start may be presented in the cycle after the handshake edge.

## Test plan
- Sum, k=2, W=16, core model with CORE_LAT=2. Pair 1: A = identity, B = all 2. Pair 2: A = identity, B = all 3. → res all 5. res_valid rises exactly 3 cycles after the last accept.
- Sum overflow, k=2: partials all 0xFFFF and all 0x0002 → res all 0x0001.
- Min, op=1, k=3: core model returns partials of constant 7, 3, 9 → res all 3. Same partials with op=2 → res all 9.
- Bubbles and backpressure, k=4: tile_valid toggles 1,0,1,0…; res_ready held 0 for 5 cycles.
  - → tile_ready drops after the 4th accept.
  - → res stable with res_valid=1 throughout the stall.
  - → busy clears on the handshake edge.
- Ignored requests:
  - start with k_tiles=0 → busy stays 0.
  - start while busy with op_in changed → core_op and the result are unaffected.
- Reset mid-DRAIN, with 2 partials in flight: assert rst for 1 cycle.
  - → all outputs 0 and state IDLE the next cycle.
  - → no res_valid afterwards.
  - → a new k=1 job then completes correctly.
